// File: rtl/product_accumulator.sv
// product_accumulator: sums a packet of 2n-bit multiplier products into an
// acc_w = 2n+guard bit accumulator and emits one registered result per packet.
// Packets are delimited by in_last. Valid/ready handshakes on both sides.
//
// Build option: define PRODUCT_ACC_SATURATE_EN to clamp the accumulator on
// overflow instead of wrapping modulo 2^acc_w. The sticky overflow flag is
// reported in both builds.
module product_accumulator #(
  parameter int unsigned n     = 8,
  parameter int unsigned guard = 8,
  parameter int unsigned cnt_w = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*n-1:0]         in_prod,
  input  logic                   in_signed,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*n+guard-1:0]   out_sum,
  output logic                   out_signed,
  output logic [cnt_w-1:0]       out_count,
  output logic                   out_ovf
);

  localparam int unsigned ACC_W = 2 * n + guard;

  // Packet state: IDLE means no packet is open, ACC means beats are being summed.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  // Running packet state
  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [cnt_w-1:0] r_count;
  logic             r_ovf;
  logic             r_mode;

  // Registered result presented downstream
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [cnt_w-1:0] r_out_count;
  logic             r_out_ovf;
  logic             r_out_signed;

  // Handshake and datapath wires
  logic             w_accept;
  logic             w_handoff;
  logic             w_first;
  logic             w_mode;
  logic [ACC_W-1:0] w_base_acc;
  logic [cnt_w-1:0] w_base_cnt;
  logic             w_base_ovf;
  logic [ACC_W-1:0] w_ext_s;
  logic [ACC_W-1:0] w_ext_u;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum_wide;
  logic             w_ovf_s;
  logic             w_ovf_u;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_next;
  logic [cnt_w-1:0] w_cnt_next;
  logic             w_ovf_next;
  logic [0:0]       w_state_next;

  // A result slot is free when empty or being drained this cycle; a last beat
  // can therefore never be accepted on top of an undrained result.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = r_out_valid && out_ready;

  // The first beat of a packet starts from a clean slate and sets the mode.
  assign w_first    = (r_state == ST_IDLE);
  assign w_mode     = w_first ? in_signed : r_mode;
  assign w_base_acc = w_first ? '0 : r_acc;
  assign w_base_cnt = w_first ? '0 : r_count;
  assign w_base_ovf = w_first ? 1'b0 : r_ovf;

  // Widen the product according to the packet mode.
  assign w_ext_s = ACC_W'($signed(in_prod));
  assign w_ext_u = ACC_W'(in_prod);
  assign w_ext   = w_mode ? w_ext_s : w_ext_u;

  // One extra bit captures the unsigned carry out.
  assign w_sum_wide = {1'b0, w_base_acc} + {1'b0, w_ext};

  // Signed overflow: like-signed addends producing a result of the other sign.
  assign w_ovf_s = (w_base_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                   (w_sum_wide[ACC_W-1] != w_base_acc[ACC_W-1]);
  assign w_ovf_u = w_sum_wide[ACC_W];
  assign w_ovf   = w_mode ? w_ovf_s : w_ovf_u;

`ifdef PRODUCT_ACC_SATURATE_EN
  // Clamp toward the overflow direction; in signed mode the direction follows
  // the (shared) sign of the addends, so the accumulator sign is enough.
  always_comb begin
    w_acc_next = w_sum_wide[ACC_W-1:0];
    if (w_ovf) begin
      if (w_mode) begin
        w_acc_next = w_base_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        w_acc_next = '1;
      end
    end
  end
`else
  assign w_acc_next = w_sum_wide[ACC_W-1:0];
`endif

  // Beat counter saturates at all-ones rather than wrapping.
  assign w_cnt_next = (&w_base_cnt) ? w_base_cnt : w_base_cnt + cnt_w'(1);
  assign w_ovf_next = w_base_ovf | w_ovf;

  // Next packet state: any accepted last beat closes the packet.
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = in_last ? ST_IDLE : ST_ACC;
    end
  end

  // Packet accumulation state; cleared on the edge that closes a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mode <= w_mode;
        if (in_last) begin
          r_acc   <= '0;
          r_count <= '0;
          r_ovf   <= 1'b0;
        end else begin
          r_acc   <= w_acc_next;
          r_count <= w_cnt_next;
          r_ovf   <= w_ovf_next;
        end
      end
    end
  end

  // Result register: loads on a last beat, otherwise holds until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_sum    <= '0;
      r_out_count  <= '0;
      r_out_ovf    <= 1'b0;
      r_out_signed <= 1'b0;
    end else begin
      if (w_accept && in_last) begin
        r_out_valid  <= 1'b1;
        r_out_sum    <= w_acc_next;
        r_out_count  <= w_cnt_next;
        r_out_ovf    <= w_ovf_next;
        r_out_signed <= w_mode;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign out_count  = r_out_count;
  assign out_ovf    = r_out_ovf;
  assign out_signed = r_out_signed;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator (n=4, guard=0, acc_w=8). A driver feeds beats
// and pushes the expected result of each packet, computed with plain integer
// arithmetic, into a queue; a monitor pops and compares on every handoff.
module tb_product_accumulator;

  localparam int unsigned N     = 4;
  localparam int unsigned GUARD = 0;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned AW    = 2 * N + GUARD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2*N-1:0] in_prod;
  logic          in_signed;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_signed;
  logic [CNT_W-1:0] out_count;
  logic          out_ovf;

  product_accumulator #(.n(N), .guard(GUARD), .cnt_w(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_signed  (in_signed),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_signed (out_signed),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sum;
    logic [7:0] cnt;
    logic       ovf;
    logic       sgn;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   stalls   = 0;
  bit   rand_rdy = 1'b0;
  bit   rand_gap = 1'b0;

  // Reference model: running packet as a plain integer
  int   m_sum;
  int   m_cnt;
  bit   m_ovf;
  bit   m_sgn;
  bit   m_open = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_beat(input logic [7:0] p, input bit sgn, input bit last);
    int v;
    int lo;
    int hi;
    exp_t e;
    if (!m_open) begin
      m_sgn  = sgn;
      m_sum  = 0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_open = 1'b1;
    end
    v  = (m_sgn && p >= 128) ? int'(p) - 256 : int'(p);
    lo = m_sgn ? -128 : 0;
    hi = m_sgn ? 127 : 255;
    m_sum = m_sum + v;
    if (m_sum < lo || m_sum > hi) begin
      m_ovf = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
      m_sum = (m_sum > hi) ? hi : lo;
`else
      m_sum = m_sum & 255;
      if (m_sgn && m_sum >= 128) m_sum = m_sum - 256;
`endif
    end
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (last) begin
      e.sum = 8'(m_sum);
      e.cnt = 8'(m_cnt);
      e.ovf = m_ovf;
      e.sgn = m_sgn;
      q.push_back(e);
      m_open = 1'b0;
    end
  endtask

  // Drive one beat from just after a rising edge; returns just after the
  // edge that accepted it.
  task automatic send_beat(input logic [7:0] p, input bit sgn, input bit last);
    int waited;
    in_valid  = 1'b1;
    in_prod   = p;
    in_signed = sgn;
    in_last   = last;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
        break;
      end
    end
    if (in_ready) model_beat(p, sgn, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, q.size(), 0);
  endtask

  // Monitor: a handoff seen in the low phase completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got sum 0x%0h with no packet pending", out_sum);
        end else begin
          mon_e = q.pop_front();
          check("out_sum",    32'(out_sum),    32'(mon_e.sum));
          check("out_count",  32'(out_count),  32'(mon_e.cnt));
          check("out_ovf",    32'(out_ovf),    32'(mon_e.ovf));
          check("out_signed", 32'(out_signed), 32'(mon_e.sgn));
        end
      end
    end
  end

  // Optional random downstream backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int outs0;
    int len;
    bit sg;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_signed = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_sum",   32'(out_sum),   0);
    check("rst_out_count", 32'(out_count), 0);
    @(posedge clk);
    #1;

    // Unsigned three-beat packet
    send_beat(8'h10, 1'b0, 1'b0);
    send_beat(8'h20, 1'b0, 1'b0);
    send_beat(8'h05, 1'b0, 1'b1);
    drain("drain_unsigned");

    // Signed packet; mode on the second beat is ignored
    send_beat(8'hF0, 1'b1, 1'b0);
    send_beat(8'h08, 1'b0, 1'b1);
    drain("drain_signed");

    // Overflow cases
    send_beat(8'h3F, 1'b1, 1'b0);
    send_beat(8'h3F, 1'b1, 1'b0);
    send_beat(8'h3F, 1'b1, 1'b1);
    send_beat(8'hFF, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b1);
    send_beat(8'h80, 1'b1, 1'b0);
    send_beat(8'hFF, 1'b1, 1'b0);
    send_beat(8'h01, 1'b1, 1'b1);
    drain("drain_ovf");

    // Backpressure then same-cycle handoff and accept
    out_ready = 1'b0;
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_prod  = 8'h44;
    in_last  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_sum",   32'(out_sum),   32'h03);
      check("bp_in_ready",  32'(in_ready),  0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send_beat(8'h09, 1'b0, 1'b1);
    check("bp_valid_stays", 32'(out_valid), 1);
    check("bp_new_sum",     32'(out_sum),   32'h09);
    drain("drain_bp");

    // Back-to-back single-beat packets
    outs0  = n_out;
    stalls = 0;
    for (int i = 0; i < 20; i++) send_beat(8'h07, 1'b0, 1'b1);
    drain("drain_single");
    check("single_stalls",  stalls, 0);
    check("single_results", n_out - outs0, 20);

    // Beat counter saturation
    for (int i = 0; i < 259; i++) send_beat(8'h00, 1'b0, 1'b0);
    send_beat(8'h01, 1'b0, 1'b1);
    drain("drain_cnt_sat");

    // Reset dropping a pending result
    out_ready = 1'b0;
    send_beat(8'h11, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready",  32'(in_ready),  1);
    check("arst_out_sum",   32'(out_sum),   0);
    q.delete();
    m_open = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Reset dropping a partial packet
    send_beat(8'h40, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_open = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(8'h05, 1'b0, 1'b1);
    drain("drain_after_reset");

    // Randomized packets with gaps and backpressure
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    for (int pk = 0; pk < 60; pk++) begin
      len = $urandom_range(1, 6);
      sg  = $urandom_range(0, 1);
      for (int b = 0; b < len; b++) begin
        send_beat(8'($urandom), ($urandom_range(0, 3) == 0) ? ~sg : sg, b == len - 1);
      end
    end
    rand_rdy = 1'b0;
    rand_gap = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
